// File: rtl/alu_scheduler_if.sv
// alu_scheduler_if: bundle of every non-clock signal of alu_scheduler.
//   Requester side : req_valid/req_ready (bit i = requester i), per-requester
//                    operands req_a*/req_b* and ALUControl code req_op*.
//   ALU side       : alu_a/alu_b/alu_ctrl out to the combinational ALU,
//                    alu_result and Z/N/V/C flags back from it.
//   Response side  : rsp_valid/rsp_ready handshake carrying rsp_id,
//                    rsp_result and rsp_flags {Z,N,V,C}.
//   Flag history   : sticky_flags {Z,N,V,C} and its clear input flags_clr.
// Modports: slave = the scheduler, master = the requesters/ALU environment.
interface alu_scheduler_if #(parameter int n = 8);
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [n-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]   req_op0, req_op1;
  logic [n-1:0] alu_a, alu_b;
  logic [3:0]   alu_ctrl;
  logic [n-1:0] alu_result;
  logic         alu_Z, alu_N, alu_V, alu_C;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [n-1:0] rsp_result;
  logic [3:0]   rsp_flags;
  logic [3:0]   sticky_flags;
  logic         flags_clr;

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
    input  alu_result, alu_Z, alu_N, alu_V, alu_C,
    input  rsp_ready, flags_clr,
    output req_ready, alu_a, alu_b, alu_ctrl,
    output rsp_valid, rsp_id, rsp_result, rsp_flags, sticky_flags
  );

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
    output alu_result, alu_Z, alu_N, alu_V, alu_C,
    output rsp_ready, flags_clr,
    input  req_ready, alu_a, alu_b, alu_ctrl,
    input  rsp_valid, rsp_id, rsp_result, rsp_flags, sticky_flags
  );
endinterface

// File: rtl/alu_scheduler.sv
// alu_scheduler: two-port round-robin arbiter and sequencer for the shared
// combinational ALU + flag generator.
//   IDLE : grant one requester (req_ready one-hot), latch its operands/op/id.
//   EXEC : one cycle driving alu_a/alu_b/alu_ctrl; result and flags captured
//          at the end of the cycle.
//   RESP : rsp_valid held with stable rsp_* until rsp_ready, then back to IDLE.
// Ports: clk, rst_n (async, active low), bus (alu_scheduler_if.slave).
// Optional feature: define ALU_STICKY_FLAGS_EN to build the sticky flag
// accumulator (sticky_flags, cleared by flags_clr); otherwise sticky_flags
// is tied to 0 and flags_clr is ignored.
module alu_scheduler #(
  parameter int n = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_scheduler_if.slave  bus
);
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  typedef struct packed {
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic [3:0]   op;
    logic         id;
  } req_t;

  req_t [NUM_REQ-1:0] req_in;
  assign req_in[0] = {bus.req_a0, bus.req_b0, bus.req_op0, 1'b0};
  assign req_in[1] = {bus.req_a1, bus.req_b1, bus.req_op1, 1'b1};

  state_e       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  req_t         lat_q, lat_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [n-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]   rsp_flags_q, rsp_flags_d;

  logic               grant_id;
  logic               accept;
  logic [NUM_REQ-1:0] req_ready;
  logic [3:0]         alu_flags;

  assign alu_flags = {bus.alu_Z, bus.alu_N, bus.alu_V, bus.alu_C};

  // Round-robin: under contention the requester that did not win last time
  // gets the ALU; a lone requester always wins. rst_n gating keeps req_ready
  // at 0 while reset is held.
  always_comb begin
    grant_id  = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];
    accept    = rst_n && (state_q == IDLE) && (|bus.req_valid);
    req_ready = accept ? (NUM_REQ'(1) << grant_id) : '0;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    lat_d        = lat_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          lat_d        = req_in[grant_id];
          last_grant_d = grant_id;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = bus.alu_result;
        rsp_flags_d  = alu_flags;
        rsp_id_d     = lat_q.id;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      lat_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lat_q        <= lat_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  // ALU operands come straight from the latch so they hold outside EXEC.
  assign bus.req_ready  = req_ready;
  assign bus.alu_a      = lat_q.a;
  assign bus.alu_b      = lat_q.b;
  assign bus.alu_ctrl   = lat_q.op;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;

`ifdef ALU_STICKY_FLAGS_EN
  logic [3:0] sticky_q, sticky_d;

  // Clear wins over a capture landing on the same edge.
  always_comb begin
    sticky_d = sticky_q;
    if (bus.flags_clr)          sticky_d = '0;
    else if (state_q == EXEC)   sticky_d = sticky_q | alu_flags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign bus.sticky_flags = sticky_q;
`else
  logic unused_flags_clr;
  assign unused_flags_clr = bus.flags_clr;
  assign bus.sticky_flags = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: directed scenarios plus a randomized run of
// alu_scheduler against a transaction-level reference model.
module tb_alu_scheduler;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_scheduler_if #(.n(N)) bus();
  alu_scheduler #(.n(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // ALU + flag generator stub. Op 4'hF passes a through and takes the flags
  // from b[3:0], so individual flags can be forced.
  logic [N:0] stub_sum;
  logic       stub_v;
  always_comb begin
    stub_sum = '0;
    stub_v   = 1'b0;
    case (bus.alu_ctrl)
      4'h0: begin
        stub_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        stub_v   = (bus.alu_a[N-1] == bus.alu_b[N-1]) && (stub_sum[N-1] != bus.alu_a[N-1]);
      end
      4'h1: begin
        stub_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 9'd1;
        stub_v   = (bus.alu_a[N-1] != bus.alu_b[N-1]) && (stub_sum[N-1] != bus.alu_a[N-1]);
      end
      4'h2:    stub_sum = {1'b0, bus.alu_a & bus.alu_b};
      4'h3:    stub_sum = {1'b0, bus.alu_a | bus.alu_b};
      default: stub_sum = {1'b0, bus.alu_a ^ bus.alu_b};
    endcase
    if (bus.alu_ctrl == 4'hF) begin
      bus.alu_result = bus.alu_a;
      {bus.alu_Z, bus.alu_N, bus.alu_V, bus.alu_C} = bus.alu_b[3:0];
    end else begin
      bus.alu_result = stub_sum[N-1:0];
      bus.alu_Z = (stub_sum[N-1:0] == '0);
      bus.alu_N = stub_sum[N-1];
      bus.alu_V = stub_v;
      bus.alu_C = stub_sum[N];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Expected {flags[3:0], result[7:0]} from plain integer arithmetic.
  function automatic logic [11:0] ref_alu(input int a, input int b, input int op);
    int r;
    bit z, ng, v, c;
    v = 0; c = 0;
    case (op)
      0: begin
        r = a + b;
        c = (r > 255);
        r = r % 256;
        v = ((a >= 128) == (b >= 128)) && ((r >= 128) != (a >= 128));
      end
      1: begin
        c = (a >= b);
        r = (a - b + 256) % 256;
        v = ((a >= 128) != (b >= 128)) && ((r >= 128) != (a >= 128));
      end
      2:  r = a & b;
      3:  r = a | b;
      15: return {4'(b), 8'(a)};
      default: r = a ^ b;
    endcase
    z  = (r == 0);
    ng = (r >= 128);
    return {z, ng, v, c, 8'(r)};
  endfunction

  function automatic logic [3:0] rnd_op();
    int k;
    k = $urandom_range(0, 4);
    return (k == 4) ? 4'hF : 4'(k);
  endfunction

  // Reference model state: one outstanding transaction at most.
  int         lg;
  bit         busy, rv;
  int         m_a, m_b, m_op;
  bit         m_id;
  logic [7:0] e_res;
  logic [3:0] e_flg;
  bit         e_id;
  logic [3:0] e_sticky;
  int         cyc;
  logic [1:0] obs_ready;

  task automatic model_reset();
    lg = 1; busy = 0; rv = 0;
    m_a = 0; m_b = 0; m_op = 0; m_id = 0;
    e_res = '0; e_flg = '0; e_id = 0; e_sticky = '0;
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0,
                       input logic [3:0] o0, input logic [7:0] a1, input logic [7:0] b1,
                       input logic [3:0] o1, input logic rr, input logic clr);
    bus.req_valid = v;
    bus.req_a0 = a0; bus.req_b0 = b0; bus.req_op0 = o0;
    bus.req_a1 = a1; bus.req_b1 = b1; bus.req_op1 = o1;
    bus.rsp_ready = rr;
    bus.flags_clr = clr;
  endtask

  // One clock cycle: drive at the negedge, check req_ready, advance the model
  // across the rising edge, then check every registered output at the next
  // negedge.
  task automatic step(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0,
                      input logic [3:0] o0, input logic [7:0] a1, input logic [7:0] b1,
                      input logic [3:0] o1, input logic rr, input logic clr);
    logic [1:0]  er;
    logic [11:0] r;
    int          g;
    drive(v, a0, b0, o0, a1, b1, o1, rr, clr);
    #1;
    er = 2'b00;
    g  = 0;
    if (!busy && v != 2'b00) begin
      g  = (v == 2'b11) ? 1 - lg : ((v == 2'b10) ? 1 : 0);
      er = 2'(1 << g);
    end
    obs_ready = bus.req_ready;
    check("req_ready", bus.req_ready, er);
    r = ref_alu(m_a, m_b, m_op);
`ifdef ALU_STICKY_FLAGS_EN
    if (clr) e_sticky = 4'b0000;
    else if (busy && !rv) e_sticky = e_sticky | r[11:8];
`endif
    if (busy && !rv) begin
      e_res = r[7:0]; e_flg = r[11:8]; e_id = m_id; rv = 1;
    end else if (busy && rv) begin
      if (rr) begin busy = 0; rv = 0; end
    end else if (er != 2'b00) begin
      busy = 1; lg = g; m_id = (g == 1);
      m_a  = (g == 1) ? int'(a1) : int'(a0);
      m_b  = (g == 1) ? int'(b1) : int'(b0);
      m_op = (g == 1) ? int'(o1) : int'(o0);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("rsp_valid",    bus.rsp_valid,    rv);
    check("rsp_result",   bus.rsp_result,   e_res);
    check("rsp_flags",    bus.rsp_flags,    e_flg);
    check("rsp_id",       bus.rsp_id,       e_id);
    check("alu_a",        bus.alu_a,        m_a);
    check("alu_b",        bus.alu_b,        m_b);
    check("alu_ctrl",     bus.alu_ctrl,     m_op);
    check("sticky_flags", bus.sticky_flags, e_sticky);
  endtask

  task automatic idle(input logic rr);
    step(2'b00, 8'h0, 8'h0, 4'h0, 8'h0, 8'h0, 4'h0, rr, 1'b0);
  endtask

  // Asynchronous reset pulse taken between edges; outputs must clear at once.
  task automatic do_reset();
    drive(2'b00, 8'h0, 8'h0, 4'h0, 8'h0, 8'h0, 4'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rst_req_ready",  bus.req_ready,    0);
    check("rst_rsp_valid",  bus.rsp_valid,    0);
    check("rst_rsp_result", bus.rsp_result,   0);
    check("rst_rsp_flags",  bus.rsp_flags,    0);
    check("rst_rsp_id",     bus.rsp_id,       0);
    check("rst_alu_a",      bus.alu_a,        0);
    check("rst_alu_b",      bus.alu_b,        0);
    check("rst_alu_ctrl",   bus.alu_ctrl,     0);
    check("rst_sticky",     bus.sticky_flags, 0);
    #2;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_ids[$];
    int acc_cyc[$];
    cyc = 0;
    model_reset();
    drive(2'b00, 8'h0, 8'h0, 4'h0, 8'h0, 8'h0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    do_reset();

    // Single request from requester 0: 3 + 5.
    step(2'b01, 8'd3, 8'd5, 4'h0, 8'h0, 8'h0, 4'h0, 1'b1, 1'b0);
    check("single_ready", obs_ready, 2'b01);
    check("single_ctrl",  bus.alu_ctrl, 4'h0);
    check("single_a",     bus.alu_a, 8'd3);
    idle(1'b1);
    check("single_valid",  bus.rsp_valid, 1);
    check("single_result", bus.rsp_result, 8'd8);
    check("single_flags",  bus.rsp_flags, 4'b0000);
    check("single_id",     bus.rsp_id, 0);
    idle(1'b1);
    check("single_done", bus.rsp_valid, 0);

    // Contention from reset: grants alternate 0,1,0,1 spaced 3 cycles.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(2'b11, 8'($urandom), 8'($urandom), rnd_op(), 8'($urandom), 8'($urandom), rnd_op(),
           1'b1, 1'b0);
      if (obs_ready != 2'b00) begin
        acc_ids.push_back(obs_ready == 2'b10 ? 1 : 0);
        acc_cyc.push_back(cyc);
      end
    end
    check("cont_count", acc_ids.size(), 4);
    for (int i = 0; i < 4 && i < acc_ids.size(); i++)
      check("cont_grant", acc_ids[i], i % 2);
    for (int i = 1; i < 4 && i < acc_cyc.size(); i++)
      check("cont_spacing", acc_cyc[i] - acc_cyc[i-1], 3);

    // Backpressure: requester 1 (7 + 9), response stalled 4 cycles.
    do_reset();
    step(2'b10, 8'h0, 8'h0, 4'h0, 8'd7, 8'd9, 4'h0, 1'b0, 1'b0);
    step(2'b11, 8'h1, 8'h1, 4'h0, 8'h2, 8'h2, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(2'b11, 8'h1, 8'h1, 4'h0, 8'h2, 8'h2, 4'h0, 1'b0, 1'b0);
      check("bp_ready",  obs_ready, 2'b00);
      check("bp_valid",  bus.rsp_valid, 1);
      check("bp_result", bus.rsp_result, 8'd16);
      check("bp_id",     bus.rsp_id, 1);
    end
    idle(1'b1);
    check("bp_xfer", bus.rsp_valid, 0);

    // Flags: 0xC0 + 0xC0 = 0x80 with carry -> N and C set.
    step(2'b01, 8'hC0, 8'hC0, 4'h0, 8'h0, 8'h0, 4'h0, 1'b1, 1'b0);
    idle(1'b1);
    check("flags_result", bus.rsp_result, 8'h80);
    check("flags_nc",     bus.rsp_flags, 4'b0101);
    idle(1'b1);

    // Reset while in EXEC aborts the transaction.
    do_reset();
    step(2'b01, 8'h11, 8'h22, 4'h1, 8'h0, 8'h0, 4'h0, 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check("abort_no_rsp", bus.rsp_valid, 0);
    end
    step(2'b10, 8'h0, 8'h0, 4'h0, 8'h21, 8'h04, 4'h3, 1'b1, 1'b0);
    check("abort_grant1", obs_ready, 2'b10);
    idle(1'b1);
    check("abort_rsp_id",  bus.rsp_id, 1);
    check("abort_rsp_res", bus.rsp_result, 8'h25);
    idle(1'b1);

    // Sticky flags: V then Z accumulate; clear pulse zeroes them.
    do_reset();
    step(2'b01, 8'h12, 8'b0010, 4'hF, 8'h0, 8'h0, 4'h0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    step(2'b01, 8'h34, 8'b1000, 4'hF, 8'h0, 8'h0, 4'h0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
`ifdef ALU_STICKY_FLAGS_EN
    check("sticky_acc", bus.sticky_flags, 4'b1010);
`else
    check("sticky_off", bus.sticky_flags, 4'b0000);
`endif
    step(2'b00, 8'h0, 8'h0, 4'h0, 8'h0, 8'h0, 4'h0, 1'b1, 1'b1);
    check("sticky_clr", bus.sticky_flags, 4'b0000);

    // Randomized traffic with random backpressure and occasional clears.
    do_reset();
    for (int i = 0; i < 400; i++)
      step(2'($urandom), 8'($urandom), 8'($urandom), rnd_op(),
           8'($urandom), 8'($urandom), rnd_op(),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
